// File: rtl/ipml_hsst_txrate_chng_sched_if.sv
// Bundle of rate-change request, lane-FSM status and scheduler outputs for one HSST quad.
// master: fabric/lane side driving the i_* signals; slave: the scheduler.
interface ipml_hsst_txrate_chng_sched_if #(
    parameter int LANE_NUM = 4
);
    logic [LANE_NUM-1:0]   i_req;
    logic [3*LANE_NUM-1:0] i_req_ckdiv;
    logic [LANE_NUM-1:0]   i_txlane_done;
    logic [LANE_NUM-1:0]   i_txckdiv_done;
    logic [LANE_NUM-1:0]   o_tx_rate_chng;
    logic [3*LANE_NUM-1:0] o_txckdiv;
    logic [LANE_NUM-1:0]   o_ack;
    logic [LANE_NUM-1:0]   o_err;
    logic                  o_busy;
    logic [1:0]            o_cur_lane;

    modport master (
        output i_req, i_req_ckdiv, i_txlane_done, i_txckdiv_done,
        input  o_tx_rate_chng, o_txckdiv, o_ack, o_err, o_busy, o_cur_lane
    );

    modport slave (
        input  i_req, i_req_ckdiv, i_txlane_done, i_txckdiv_done,
        output o_tx_rate_chng, o_txckdiv, o_ack, o_err, o_busy, o_cur_lane
    );
endinterface

// File: rtl/ipml_hsst_txrate_chng_sched.sv
// Serialises TX rate-change requests onto the per-lane TX reset FSMs, one lane at a time.
// Define IPML_HSST_TXRATE_SCHED_FIXED_PRIO_EN for fixed priority (lane 0 highest) instead of round-robin.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | arbitrate among eligible lanes (req & txlane_done)
// SETUP     | new divider already on o_txckdiv[lane], strobe not yet raised
// ASSERT    | o_tx_rate_chng[lane] high for PULSE_CYC cycles
// WAIT_CLR  | wait for the lane's ckdiv-done to drop (timeout counting)
// WAIT_DONE | wait for ckdiv-done and txlane-done (timeout counting)
// ACK       | o_ack[lane] high for one cycle, pointer advanced
module ipml_hsst_txrate_chng_sched #(
    parameter int         LANE_NUM        = 4,
    parameter int         FREE_CLOCK_FREQ = 100,
    parameter int         TIMEOUT_US      = 10,
    parameter int         PULSE_CYC       = 4,
    parameter logic [2:0] INIT_CKDIV      = 3'd0
) (
    input logic clk,
    input logic rst_n,
    ipml_hsst_txrate_chng_sched_if.slave bus
);

    localparam int          TIMEOUT_CYC = TIMEOUT_US * FREE_CLOCK_FREQ;
    localparam logic [15:0] TO_LAST     = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  PULSE_LAST  = 4'(PULSE_CYC - 1);
    localparam logic [1:0]  LAST_LANE   = 2'(LANE_NUM - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ASSERT,
        WAIT_CLR,
        WAIT_DONE,
        ACK
    } state_t;

    state_t              state;
    logic [1:0]          rr_ptr;
    logic [LANE_NUM-1:0] cur_oh;
    logic [3:0]          pulse_cnt;
    logic [15:0]         to_cnt;

    logic [LANE_NUM-1:0] elig;
    logic [LANE_NUM-1:0] sel_oh;
    logic [1:0]          sel_idx;
    logic                found;
    logic                clr_seen;
    logic                done_seen;
    logic [1:0]          ptr_next;

    assign elig      = bus.i_req & bus.i_txlane_done;
    assign clr_seen  = ~|(bus.i_txckdiv_done & cur_oh);
    assign done_seen = |(bus.i_txckdiv_done & bus.i_txlane_done & cur_oh);
    assign ptr_next  = (bus.o_cur_lane == LAST_LANE) ? 2'd0 : bus.o_cur_lane + 2'd1;

    // First eligible lane at or after the pointer, wrapping modulo LANE_NUM.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        for (int i = 0; i < LANE_NUM; i++) begin
            for (int n = 0; n < LANE_NUM; n++) begin
                if (!found && elig[n] && (((int'(rr_ptr) + i) % LANE_NUM) == n)) begin
                    found     = 1'b1;
                    sel_idx   = 2'(n);
                    sel_oh[n] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            rr_ptr             <= '0;
            cur_oh             <= '0;
            pulse_cnt          <= '0;
            to_cnt             <= '0;
            bus.o_tx_rate_chng <= '0;
            bus.o_txckdiv      <= {LANE_NUM{INIT_CKDIV}};
            bus.o_ack          <= '0;
            bus.o_err          <= '0;
            bus.o_busy         <= 1'b0;
            bus.o_cur_lane     <= '0;
        end else begin
            bus.o_ack <= '0;
            bus.o_err <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        // Divider goes out a cycle ahead of the strobe so the lane FSM sees it settled.
                        for (int n = 0; n < LANE_NUM; n++) begin
                            if (sel_oh[n]) begin
                                bus.o_txckdiv[3*n +: 3] <= bus.i_req_ckdiv[3*n +: 3];
                            end
                        end
                        cur_oh         <= sel_oh;
                        bus.o_cur_lane <= sel_idx;
                        bus.o_busy     <= 1'b1;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    bus.o_tx_rate_chng <= cur_oh;
                    pulse_cnt          <= PULSE_LAST;
                    state              <= ASSERT;
                end
                ASSERT: begin
                    if (pulse_cnt == 4'd0) begin
                        bus.o_tx_rate_chng <= '0;
                        to_cnt             <= '0;
                        state              <= WAIT_CLR;
                    end else begin
                        pulse_cnt <= pulse_cnt - 4'd1;
                    end
                end
                WAIT_CLR, WAIT_DONE: begin
                    if (state == WAIT_CLR && clr_seen) begin
                        to_cnt <= to_cnt + 16'd1;
                        state  <= WAIT_DONE;
                    end else if (state == WAIT_DONE && done_seen) begin
                        bus.o_ack <= cur_oh;
`ifndef IPML_HSST_TXRATE_SCHED_FIXED_PRIO_EN
                        rr_ptr    <= ptr_next;
`endif
                        state     <= ACK;
                    end else if (to_cnt == TO_LAST) begin
                        // Lane keeps the new divider; only the service is abandoned.
                        bus.o_err  <= cur_oh;
                        bus.o_busy <= 1'b0;
`ifndef IPML_HSST_TXRATE_SCHED_FIXED_PRIO_EN
                        rr_ptr     <= ptr_next;
`endif
                        state      <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                ACK: begin
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    bus.o_tx_rate_chng <= '0;
                    bus.o_busy         <= 1'b0;
                    state              <= IDLE;
                end
            endcase
        end
    end

endmodule
